// File: rtl/ets_acq_sequencer.sv
// ets_acq_sequencer: arms on an external trigger edge, fires the ETS sampler and
// turns its sample strobes into buffer write addresses over a multi-frame acquisition.
module ets_acq_sequencer #(
    parameter int POINT_NUM = 256,
    parameter int ADDR_W    = 8,
    parameter int FRAME_W   = 8,
    parameter int TMR_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FRAME_W-1:0] cfg_frames,
    input  logic [TMR_W-1:0]   cfg_holdoff,
    input  logic [TMR_W-1:0]   cfg_timeout,
    input  logic               ext_trig,
    input  logic               smp_busy,
    input  logic               smp_sp_en,
    output logic               smp_trigger,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [FRAME_W-1:0] wr_frame,
    output logic               acq_busy,
    output logic               acq_done,
    output logic               err_timeout,
    output logic               err_count
);
    localparam int PT_W = $clog2(POINT_NUM + 1);
    localparam logic [PT_W-1:0] PT_FULL = PT_W'(POINT_NUM);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_FIRE, S_RUN, S_HOLD} state_t;

    state_t             r_state, w_state;
    logic               r_trig_d, r_busy_d;
    logic [PT_W-1:0]    r_pt, w_pt;
    logic [TMR_W-1:0]   r_tmr, w_tmr, r_holdoff, w_holdoff, r_timeout, w_timeout;
    logic [FRAME_W-1:0] r_frames, w_frames, r_frame, w_frame;
    logic [ADDR_W-1:0]  r_addr, w_addr;
    logic               r_fire, w_fire, r_wr, w_wr, r_busy, w_busy, r_done, w_done;
    logic               r_err_to, w_err_to, r_err_cnt, w_err_cnt;
    logic               w_edge, w_fall, w_strobe;
    logic [TMR_W-1:0]   w_tmr_inc;

    assign w_edge    = ext_trig & ~r_trig_d;
    assign w_fall    = r_busy_d & ~smp_busy;
    assign w_strobe  = smp_sp_en && (r_state == S_FIRE || r_state == S_RUN);
    assign w_tmr_inc = r_tmr + TMR_W'(1);

    always_comb begin
        w_state   = r_state;
        w_pt      = r_pt;
        w_tmr     = r_tmr;
        w_holdoff = r_holdoff;
        w_timeout = r_timeout;
        w_frames  = r_frames;
        w_frame   = r_frame;
        w_addr    = r_addr;
        w_fire    = 1'b0;
        w_wr      = 1'b0;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_err_to  = r_err_to;
        w_err_cnt = r_err_cnt;
        if (w_strobe) begin
            if (r_pt < PT_FULL) begin
                w_wr   = 1'b1;
                w_addr = ADDR_W'(r_pt);
                w_pt   = r_pt + PT_W'(1);
            end else begin
                w_err_cnt = 1'b1;
            end
        end
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_frames  = (cfg_frames == '0) ? FRAME_W'(1) : cfg_frames;
                    w_holdoff = cfg_holdoff;
                    w_timeout = cfg_timeout;
                    w_err_to  = 1'b0;
                    w_err_cnt = 1'b0;
                    w_frame   = '0;
                    w_pt      = '0;
                    w_tmr     = '0;
                    w_busy    = 1'b1;
                    w_state   = S_ARM;
                end
            end
            S_ARM: begin
                w_tmr = w_tmr_inc;
                if (w_edge && !smp_busy) begin
                    w_fire  = 1'b1;
                    w_state = S_FIRE;
                end else if (r_timeout != '0 && w_tmr_inc == r_timeout) begin
                    w_err_to = 1'b1;
                    w_done   = 1'b1;
                    w_busy   = 1'b0;
                    w_state  = S_IDLE;
                end
            end
            S_FIRE: w_state = smp_busy ? S_RUN : S_FIRE;
            S_RUN: begin
                if (w_fall) begin
                    // a strobe landing on the falling edge still counts toward the frame
                    w_err_cnt = w_err_cnt | (w_pt != PT_FULL);
                    w_pt      = '0;
                    w_tmr     = '0;
                    if (r_frame == r_frames - FRAME_W'(1)) begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end else begin
                        w_frame = r_frame + FRAME_W'(1);
                        w_state = (r_holdoff == '0) ? S_ARM : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                w_tmr = w_tmr_inc;
                if (w_tmr_inc == r_holdoff) begin
                    w_tmr   = '0;
                    w_state = S_ARM;
                end
            end
            default: w_state = S_IDLE;
        endcase
        if (abort && r_state != S_IDLE) begin
            w_state   = S_IDLE;
            w_fire    = 1'b0;
            w_wr      = 1'b0;
            w_done    = 1'b0;
            w_busy    = 1'b0;
            w_err_to  = r_err_to;
            w_err_cnt = r_err_cnt;
            w_frame   = r_frame;
            w_pt      = '0;
            w_tmr     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_trig_d  <= 1'b0;
            r_busy_d  <= 1'b0;
            r_pt      <= '0;
            r_tmr     <= '0;
            r_holdoff <= '0;
            r_timeout <= '0;
            r_frames  <= '0;
            r_frame   <= '0;
            r_addr    <= '0;
            r_fire    <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_cnt <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_trig_d  <= ext_trig;
            r_busy_d  <= smp_busy;
            r_pt      <= w_pt;
            r_tmr     <= w_tmr;
            r_holdoff <= w_holdoff;
            r_timeout <= w_timeout;
            r_frames  <= w_frames;
            r_frame   <= w_frame;
            r_addr    <= w_addr;
            r_fire    <= w_fire;
            r_wr      <= w_wr;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err_to  <= w_err_to;
            r_err_cnt <= w_err_cnt;
        end
    end

    assign smp_trigger = r_fire;
    assign wr_en       = r_wr;
    assign wr_addr     = r_addr;
    assign wr_frame    = r_frame;
    assign acq_busy    = r_busy;
    assign acq_done    = r_done;
    assign err_timeout = r_err_to;
    assign err_count   = r_err_cnt;
endmodule
